// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment glyphs
// (active-low {g,f,e,d,c,b,a}) and the active-low digit-enable codes.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Hex glyphs; element [v] is the glyph for value v (uppercase A,C,E,F; lowercase b,d).
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [3:0] AN_BLANK = 4'b1111;
  localparam logic [3:0] AN_IDX0  = 4'b0111;
  localparam logic [3:0] AN_IDX1  = 4'b1011;
  localparam logic [3:0] AN_IDX2  = 4'b1101;
  localparam logic [3:0] AN_IDX3  = 4'b1110;

  // Digit-enable pattern for a scan index.
  function automatic logic [3:0] an_for_idx(input logic [1:0] idx);
    logic [3:0] an_v;
    case (idx)
      2'd0:    an_v = AN_IDX0;
      2'd1:    an_v = AN_IDX1;
      2'd2:    an_v = AN_IDX2;
      2'd3:    an_v = AN_IDX3;
      default: an_v = AN_BLANK;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit to active-low seven-segment glyph decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver. Captures ALU
// operands/select/result on a load strobe and scans them continuously,
// with a one-cycle blank at the end of every digit slot.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] rs,
  input  logic [3:0] rt,
  input  logic [2:0] sel,
  input  logic [3:0] rd,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       valid
);

  localparam int              DW       = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [3:0]    r_rs;
  logic [3:0]    r_rt;
  logic [2:0]    r_sel;
  logic [3:0]    r_rd;
  logic          r_valid;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_wrap;
  logic [3:0]    w_nibble;
  logic [6:0]    w_glyph;

  // Last cycle of a slot: blank the display and advance the index on this edge.
  assign w_wrap = (r_div == DIV_LAST);

  // Slot divider counting 0..REFRESH_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Digit index advances once per slot, wrapping 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_idx <= r_idx + 2'd1;
    end else begin
      r_idx <= r_idx;
    end
  end

  // Shadow registers and valid flag; every load overwrites, scan state is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs    <= 4'h0;
      r_rt    <= 4'h0;
      r_sel   <= 3'h0;
      r_rd    <= 4'h0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_rs    <= rs;
      r_rt    <= rt;
      r_sel   <= sel;
      r_rd    <= rd;
      r_valid <= 1'b1;
    end else begin
      r_rs    <= r_rs;
      r_rt    <= r_rt;
      r_sel   <= r_sel;
      r_rd    <= r_rd;
      r_valid <= r_valid;
    end
  end

  // Select the nibble belonging to the digit currently being scanned.
  always_comb begin
    w_nibble = 4'h0;
    case (r_idx)
      2'd3:    w_nibble = r_rs;
      2'd2:    w_nibble = r_rt;
      2'd1:    w_nibble = {1'b0, r_sel};
      2'd0:    w_nibble = r_rd;
      default: w_nibble = 4'h0;
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Output pins registered from scan state; dashes until the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_BLANK;
      r_seg <= SEG_BLANK;
    end else if (w_wrap) begin
      r_an  <= AN_BLANK;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= an_for_idx(r_idx);
      r_seg <= r_valid ? w_glyph : SEG_DASH;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign valid = r_valid;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with REFRESH_DIV=4.
// A cycle-count model predicts the pins every cycle; directed scenarios add
// hand-computed literal expectations.
module tb_seven_seg_scan_driver;

  localparam int RD = 4;

  // Bench-owned glyph table, element [v] for value v, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] rs = 4'h0;
  logic [3:0] rt = 4'h0;
  logic [2:0] sel = 3'h0;
  logic [3:0] rd = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .rs    (rs),
    .rt    (rt),
    .sel   (sel),
    .rd    (rd),
    .an    (an),
    .seg   (seg),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // t = number of clock edges since reset; slot position = t mod RD, digit = (t/RD) mod 4.
  int unsigned m_t = 0;
  logic [3:0]  m_rs = 4'h0, m_rt = 4'h0, m_rd = 4'h0;
  logic [2:0]  m_sel = 3'h0;
  logic        m_valid = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_valid = 1'b0;

  function automatic logic [3:0] f_an(input int unsigned t);
    logic [3:0] one;
    one = 4'b1000;
    if ((t % RD) == RD - 1) return 4'hF;
    return ~(one >> ((t / RD) % 4));
  endfunction

  function automatic logic [6:0] f_seg(input int unsigned t, input logic [3:0] a,
                                       input logic [3:0] b, input logic [2:0] s,
                                       input logic [3:0] r, input logic v);
    logic [3:0] val;
    if ((t % RD) == RD - 1) return 7'h7F;
    if (!v) return 7'h3F;
    case ((t / RD) % 4)
      3:       val = a;
      2:       val = b;
      1:       val = {1'b0, s};
      default: val = r;
    endcase
    return GLY[val];
  endfunction

  // Model update: outputs come from the pre-edge state, then captures apply.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_rs <= 4'h0; m_rt <= 4'h0; m_sel <= 3'h0; m_rd <= 4'h0;
      m_valid <= 1'b0; e_an <= 4'hF; e_seg <= 7'h7F; e_valid <= 1'b0;
    end else begin
      e_an    <= f_an(m_t);
      e_seg   <= f_seg(m_t, m_rs, m_rt, m_sel, m_rd, m_valid);
      e_valid <= m_valid | load;
      m_t     <= m_t + 1;
      if (load) begin
        m_rs <= rs; m_rt <= rt; m_sel <= sel; m_rd <= rd; m_valid <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of the pins against the model.
  always @(negedge clk) begin
    check("model_an", {28'd0, an}, {28'd0, e_an});
    check("model_seg", {25'd0, seg}, {25'd0, e_seg});
    check("model_valid", {31'd0, valid}, {31'd0, e_valid});
  end

  task automatic pulse_load(input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] s, input logic [3:0] r);
    rs = a; rt = b; sel = s; rd = r; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [3:0] rst_seq [5];
  logic seen_d, seen_5, seen_a, seen_3, seen1, seen2;

  initial begin
    rst_seq = '{4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1011};

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_valid", {31'd0, valid}, 32'd0);
    rst_n = 1'b1;

    // Post-reset scan sequence with dashes
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_seq_an", {28'd0, an}, {28'd0, rst_seq[i]});
      if (rst_seq[i] != 4'hF) check("rst_seq_dash", {25'd0, seg}, 32'h3F);
    end

    // Load and scan: rs=3 rt=A sel=5 rd=D
    pulse_load(4'h3, 4'hA, 3'h5, 4'hD);
    check("load_valid", {31'd0, valid}, 32'd1);
    seen_d = 1'b0; seen_5 = 1'b0; seen_a = 1'b0; seen_3 = 1'b0;
    for (int i = 0; i < 4 * RD + 2; i++) begin
      @(negedge clk);
      if (an == 4'b0111 && seg == 7'b0100001) seen_d = 1'b1;
      if (an == 4'b1011 && seg == 7'b0010010) seen_5 = 1'b1;
      if (an == 4'b1101 && seg == 7'b0001000) seen_a = 1'b1;
      if (an == 4'b1110 && seg == 7'b0110000) seen_3 = 1'b1;
    end
    check("scan_idx0_d", {31'd0, seen_d}, 32'd1);
    check("scan_idx1_5", {31'd0, seen_5}, 32'd1);
    check("scan_idx2_A", {31'd0, seen_a}, 32'd1);
    check("scan_idx3_3", {31'd0, seen_3}, 32'd1);

    // Glyph sweep on the idx 0 digit
    for (int v = 0; v < 16; v++) begin
      pulse_load(4'h3, 4'hA, 3'h5, 4'(v));
      @(negedge clk);
      for (int i = 0; i < 4 * RD - 1; i++) begin
        @(negedge clk);
        if (an == 4'b0111) check("sweep_glyph", {25'd0, seg}, {25'd0, GLY[v]});
      end
    end

    // Back-to-back load: rd=1 then rd=2
    rs = 4'h3; rt = 4'hA; sel = 3'h5; rd = 4'h1; load = 1'b1;
    @(negedge clk);
    rd = 4'h2;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    seen1 = 1'b0; seen2 = 1'b0;
    for (int i = 0; i < 5 * RD; i++) begin
      @(negedge clk);
      if (an == 4'b0111 && seg == 7'b1111001) seen1 = 1'b1;
      if (an == 4'b0111 && seg == 7'b0100100) seen2 = 1'b1;
    end
    check("b2b_never_1", {31'd0, seen1}, 32'd0);
    check("b2b_shows_2", {31'd0, seen2}, 32'd1);

    // Load coinciding with the divider wrap
    for (int i = 0; i < 2 * RD; i++) begin
      if ((m_t % RD) == RD - 1) break;
      @(negedge clk);
    end
    check("wrap_aligned", {31'd0, 1'b0}, {31'd0, ((m_t % RD) != RD - 1)});
    pulse_load(4'h7, 4'hE, 3'h6, 4'hB);
    check("wrap_blank_an", {28'd0, an}, 32'hF);
    repeat (5 * RD) @(negedge clk);

    // Asynchronous reset mid-frame
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", {28'd0, an}, 32'hF);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4 * RD + 1; i++) begin
      @(negedge clk);
      if (an != 4'hF) check("post_rst_dash", {25'd0, seg}, 32'h3F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
